l1_dcache_ctrl: RTL and testbench

//  Per-core L1 data cache between the processor's load/store port and the shared memory bus.

---
 rtl/l1_dcache_ctrl_pkg.sv | 32 +++
 rtl/l1_dcache_ctrl_if.sv | 44 ++++
 rtl/l1_dcache_ctrl_line_array.sv | 59 +++++
 rtl/l1_dcache_ctrl.sv | 147 ++++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_dcache_ctrl_pkg.sv
// Shared types and helpers for the L1 data cache controller.
//   state_e       controller FSM states
//   MASK_*        load/store size codes (funct3 encoding)
//   be_from_mask  byte-enable pattern for a store of a given size at a byte offset
package l1_dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  // Unsigned size codes on a store are treated like their signed twins,
  // since sign only matters on the load path.
  function automatic logic [3:0] be_from_mask(input logic [2:0] mask,
                                              input logic [1:0] off);
    logic [3:0] be;
    case (mask)
      MASK_B, MASK_BU: be = 4'b0001 << off;
      MASK_H, MASK_HU: be = 4'b0011 << {off[1], 1'b0};
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/l1_dcache_ctrl_if.sv
// Bus bundle for the L1 data cache: core load/store port, memory bus and
// snoop input.
//   slave  : cache side (used by l1_dcache_ctrl)
//   master : environment side (core + memory + snoop source)
// Handshakes:
//   core : cpu_req is valid; the core holds all cpu_* stable until the cycle
//          in which cpu_ready=1, and the request completes in that cycle.
//   bus  : mem_req (with mem_we/addr/wdata/be) is held until a one-cycle
//          mem_ack pulse; mem_rdata is valid only with mem_ack.
//   snoop: snoop_inv is a single-cycle event with no back-pressure.
interface l1_dcache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        snoop_inv;
  logic [31:0] snoop_addr;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack,
    input  snoop_inv, snoop_addr
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack,
    output snoop_inv, snoop_addr
  );
endinterface

// File: rtl/l1_dcache_ctrl_line_array.sv
// Flop-based line storage for the direct-mapped cache.
//   clk, reset            clock, async active-low reset (clears valid bits only)
//   rd_index -> rd_*      combinational read port (core index)
//   wr_en/index/tag/data  write port (fill or store merge); sets valid
//   snoop_en/index/tag    invalidate port; beats a same-cycle write to the line
module l1_dcache_ctrl_line_array #(
  parameter int SETS    = 64,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               snoop_en,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];
  logic             snoop_kill;

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  // The snoop is compared against the stored line and also against a line
  // being written this cycle, so a fill racing a remote write to the same
  // address ends invalid.
  assign snoop_kill = snoop_en &&
                      ((valid_q[snoop_index] && (tag_q[snoop_index] == snoop_tag)) ||
                       (wr_en && (wr_index == snoop_index) && (wr_tag == snoop_tag)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (wr_en)      valid_q[wr_index]    <= 1'b1;
      if (snoop_kill) valid_q[snoop_index] <= 1'b0;
    end
  end

  // Tag and data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// L1 data cache controller: direct-mapped, one word per line, write-through,
// no-write-allocate, snoop invalidation.
//   clk, reset         clock, async active-low reset
//   bus (slave)        core port, memory bus and snoop input
//   hit_cnt, miss_cnt  saturating load hit/miss statistics
//   dbg_state          current FSM state
module l1_dcache_ctrl
  import l1_dcache_ctrl_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  l1_dcache_ctrl_if.slave   bus,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output state_e            dbg_state
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = 30 - INDEX_W;

  state_e       state_q;
  logic         mem_req_q;
  logic         mem_we_q;
  logic [31:0]  mem_addr_q;
  logic [31:0]  mem_wdata_q;
  logic [3:0]   mem_be_q;

  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] snoop_index;
  logic [TAG_W-1:0]   snoop_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               cpu_hit;
  logic               fill;
  logic               merge;
  logic               wr_en;
  logic [31:0]        merged;
  logic [31:0]        wr_data;
  logic               unused_snoop_bits;

  assign cpu_index   = bus.cpu_addr[2 +: INDEX_W];
  assign cpu_tag     = bus.cpu_addr[31 -: TAG_W];
  assign snoop_index = bus.snoop_addr[2 +: INDEX_W];
  assign snoop_tag   = bus.snoop_addr[31 -: TAG_W];
  assign unused_snoop_bits = ^bus.snoop_addr[1:0];

  assign cpu_hit = rd_valid && (rd_tag == cpu_tag);

  // Fill lands on the registered miss address so it completes even if the
  // core drops its request meanwhile. A store merges only into a line that
  // already holds the address; the core keeps cpu_addr stable during the store.
  assign fill  = (state_q == RD_MISS) && bus.mem_ack;
  assign merge = (state_q == WR_THRU) && bus.mem_ack && cpu_hit;
  assign wr_en = fill || merge;

  always_comb begin
    merged = rd_data;
    for (int b = 0; b < 4; b++) begin
      if (mem_be_q[b]) merged[8*b +: 8] = mem_wdata_q[8*b +: 8];
    end
  end

  assign wr_data = fill ? bus.mem_rdata : merged;

  l1_dcache_ctrl_line_array #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk         (clk),
    .reset       (reset),
    .rd_index    (cpu_index),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_index    (mem_addr_q[2 +: INDEX_W]),
    .wr_tag      (mem_addr_q[31 -: TAG_W]),
    .wr_data     (wr_data),
    .snoop_en    (bus.snoop_inv),
    .snoop_index (snoop_index),
    .snoop_tag   (snoop_tag)
  );

  // Read hits complete in the request cycle; stores complete with the ack.
  assign bus.cpu_ready = ((state_q == IDLE) && bus.cpu_req && !bus.cpu_we && cpu_hit) ||
                         ((state_q == WR_THRU) && bus.mem_ack);
  assign bus.cpu_rdata = rd_data;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign dbg_state     = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req && !bus.cpu_we) begin
            if (cpu_hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {bus.cpu_addr[31:2], 2'b00};
              mem_be_q   <= 4'b1111;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
              state_q    <= RD_MISS;
            end
          end else if (bus.cpu_req && bus.cpu_we) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.cpu_addr[31:2], 2'b00};
            mem_be_q    <= be_from_mask(bus.cpu_mask, bus.cpu_addr[1:0]);
            mem_wdata_q <= bus.cpu_wdata << (8 * bus.cpu_addr[1:0]);
            state_q     <= WR_THRU;
          end
        end
        RD_MISS, WR_THRU: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_l1_dcache_ctrl;
  import l1_dcache_ctrl_pkg::*;

  logic             clk;
  logic             reset;
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;
  state_e           dbg_state;

  int n_assert;
  int n_fail;
  int exp_hit;
  int exp_miss;

  l1_dcache_ctrl_if bus ();

  l1_dcache_ctrl #(.SETS(64), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // All tasks start and end just after a falling edge.
  task automatic drive_load(input logic [31:0] a);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = a;
    bus.cpu_mask  = MASK_W;
    bus.cpu_wdata = 32'h0;
  endtask

  task automatic load_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive_load(a);
    #1;
    chk({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    chk({tag, "_rdata"}, bus.cpu_rdata, exp);
    chk({tag, "_no_req"}, 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    exp_hit++;
    #1;
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hit));
  endtask

  // Miss, fill with fill_data, then the held request hits one cycle after ack.
  task automatic load_miss(input string tag, input logic [31:0] a, input logic [31:0] fill_data);
    drive_load(a);
    #1;
    chk({tag, "_ready_miss"}, 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    #1;
    exp_miss++;
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    chk({tag, "_miss_cnt"}, miss_cnt, 32'(exp_miss));
    chk({tag, "_state"}, 32'(dbg_state), 32'(RD_MISS));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = fill_data;
    #1;
    chk({tag, "_ready_on_ack"}, 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    chk({tag, "_ready_after"}, 32'(bus.cpu_ready), 32'd1);
    chk({tag, "_rdata"}, bus.cpu_rdata, fill_data);
    chk({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    exp_hit++;
    #1;
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hit));
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] mask, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_mask  = mask;
    #1;
    chk({tag, "_ready_req"}, 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd1);
    chk({tag, "_mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'(exp_be));
    chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
    chk({tag, "_state"}, 32'(dbg_state), 32'(WR_THRU));
    chk({tag, "_ready_wait"}, 32'(bus.cpu_ready), 32'd0);
    bus.mem_ack = 1'b1;
    #1;
    chk({tag, "_ready_ack"}, 32'(bus.cpu_ready), 32'd1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hit));
    chk({tag, "_miss_cnt"}, miss_cnt, 32'(exp_miss));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_hit  = 0;
    exp_miss = 0;
    reset          = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h0;
    bus.cpu_mask   = MASK_W;
    bus.mem_rdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.snoop_inv  = 1'b0;
    bus.snoop_addr = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: cold miss and fill; the held load completes as a hit after the fill
    load_miss("t1_lw100", 32'h0000_0100, 32'hDEAD_BEEF);

    // 2: repeat hits in the request cycle; same index, other tag replaces the line
    load_hit("t2_lw100", 32'h0000_0100, 32'hDEAD_BEEF);
    load_miss("t2_lw200", 32'h0000_0200, 32'h1234_5678);
    load_miss("t2_lw100_again", 32'h0000_0100, 32'hDEAD_BEEF);

    // 3: byte store merges into a cached line; full word store too
    store("t3_sb101", 32'h0000_0101, 32'h0000_00AA, MASK_B, 4'b0010, 32'h0000_AA00);
    load_hit("t3_lw100", 32'h0000_0100, 32'hDEAD_AAEF);
    store("t3_sw100", 32'h0000_0100, 32'h1122_3344, MASK_W, 4'b1111, 32'h1122_3344);
    load_hit("t3_lw100_w", 32'h0000_0100, 32'h1122_3344);

    // 4: halfword store to an uncached address does not allocate
    store("t4_sh302", 32'h0000_0302, 32'h0000_BEEF, MASK_H, 4'b1100, 32'hBEEF_0000);
    load_miss("t4_lw300", 32'h0000_0300, 32'hCAFE_F00D);
    // BU code on a store behaves as a byte store
    store("t4_sbu303", 32'h0000_0303, 32'h0000_0055, MASK_BU, 4'b1000, 32'h5500_0000);
    load_hit("t4_lw300_m", 32'h0000_0300, 32'h55FE_F00D);

    // 5: snoop racing the fill invalidates; held load re-issues
    drive_load(32'h0000_0140);
    @(negedge clk);
    #1;
    exp_miss++;
    chk("t5_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t5_mem_addr", bus.mem_addr, 32'h0000_0140);
    chk("t5_miss_cnt", miss_cnt, 32'(exp_miss));
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'h0BAD_F00D;
    bus.snoop_inv  = 1'b1;
    bus.snoop_addr = 32'h0000_0140;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.snoop_inv = 1'b0;
    #1;
    chk("t5_ready_after_kill", 32'(bus.cpu_ready), 32'd0);
    chk("t5_state_idle", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #1;
    exp_miss++;
    chk("t5_reissue_req", 32'(bus.mem_req), 32'd1);
    chk("t5_reissue_state", 32'(dbg_state), 32'(RD_MISS));
    chk("t5_reissue_miss_cnt", miss_cnt, 32'(exp_miss));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("t5_ready_refill", 32'(bus.cpu_ready), 32'd1);
    chk("t5_rdata_refill", bus.cpu_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    exp_hit++;
    // Snoops to another line and to the same index with another tag leave it valid
    bus.snoop_inv  = 1'b1;
    bus.snoop_addr = 32'h0000_0144;
    @(negedge clk);
    bus.snoop_addr = 32'h0000_0240;
    @(negedge clk);
    bus.snoop_inv  = 1'b0;
    load_hit("t5_lw140_kept", 32'h0000_0140, 32'h0BAD_F00D);
    // An idle snoop to the line invalidates it
    bus.snoop_inv  = 1'b1;
    bus.snoop_addr = 32'h0000_0142;
    @(negedge clk);
    bus.snoop_inv  = 1'b0;
    load_miss("t5_lw140_gone", 32'h0000_0140, 32'h1111_1111);

    // 6: reset in the middle of a read miss
    drive_load(32'h0000_0400);
    @(negedge clk);
    #1;
    chk("t6_mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_req_dropped", 32'(bus.mem_req), 32'd0);
    chk("t6_hit_cnt_clr", hit_cnt, 32'd0);
    chk("t6_miss_cnt_clr", miss_cnt, 32'd0);
    chk("t6_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("t6_mem_addr_clr", bus.mem_addr, 32'h0);
    bus.cpu_req = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    @(negedge clk);
    reset = 1'b1;
    // Stray ack in IDLE
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    #1;
    chk("t6_stray_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_stray_req", 32'(bus.mem_req), 32'd0);
    chk("t6_stray_hit_cnt", hit_cnt, 32'd0);
    // Lines that were valid before reset now miss
    load_miss("t6_lw300", 32'h0000_0300, 32'h2222_2222);
    load_miss("t6_lw140", 32'h0000_0140, 32'h3333_3333);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
